ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the dual-port RAM. It owns the write and read pointers and drives the RAM's write and read ports.
- It presents a push/pop interface to the producer and consumer and returns RAM read data with a valid strobe.
- It generates full, empty, almost-full, occupancy and error flags.
- Storage lives entirely in the RAM; this block holds only pointers, counters and flags.

Parameters:
- DATA_WIDTH, 8, width of push/pop data and of RAM data.
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH = 16.
- AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- push  input  1  producer write request.
- push_data  input  DATA_WIDTH  data to store.
- pop  input  1  consumer read request.
- pop_data  output  DATA_WIDTH  data returned, qualified by pop_valid.
- pop_valid  output  1  pop_data valid, one cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push rejected because full.
- underflow  output  1  one-cycle pulse: pop rejected because empty.
- ram_wr_enb  output  1  to RAM wr_enb.
- ram_wr_addr  output  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data  output  DATA_WIDTH  to RAM wr_data.
- ram_rd_enb  output  1  to RAM rd_enb.
- ram_rd_addr  output  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  input  DATA_WIDTH  from RAM rd_data; registered, valid one cycle after rd_enb.

Behaviour:
- Reset (rst=0, asynchronous assertion):
  - wr_ptr, rd_ptr and count clear to 0; empty=1.
  - full, almost_full, overflow, underflow and pop_valid clear to 0; pop_data clears to 0.
  - RAM contents are not cleared.
- Reset release is synchronised: two-flop deassert synchroniser on rst inside the block.
- Pointers are ADDR_WIDTH+1 bits. RAM address = low ADDR_WIDTH bits.
  - Wrap: the MSB toggles when the low bits roll 15 -> 0.
  - full = (MSB differ, low bits equal); empty = (pointers equal).
- Accepted push (push && !full):
  - ram_wr_enb=1 combinationally, ram_wr_addr=wr_ptr[ADDR_WIDTH-1:0], ram_wr_data=push_data in the same cycle.
  - wr_ptr increments at the edge.
- Accepted pop (pop && !empty):
  - ram_rd_enb=1, ram_rd_addr=rd_ptr[ADDR_WIDTH-1:0] in the same cycle; rd_ptr increments at the edge.
  - pop_valid is a registered flag set the next cycle; pop_data = ram_rd_data in that cycle.
  - Total pop latency: 1 cycle.
- Rejected push or pop:
  - No RAM enable and no pointer change.
  - overflow or underflow pulses high for exactly one cycle (registered).
- Simultaneous push and pop: each is evaluated against the current-cycle flags independently.
  - Not full and not empty: both accepted, count unchanged. Write and read addresses necessarily differ.
  - Full: pop accepted, push rejected with overflow.
  - Empty: push accepted, pop rejected with underflow. Written data is not bypassed.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. All flags are derived from the registered pointers and count.
- Reset asserted mid-operation: an in-flight pop_valid is cleared and no pulse is produced after reset.

Decomposition:
- Shared package pkg gains:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - localparam DEPTH.
  - Typedefs ptr_t (ADDR_WIDTH+1 bits), addr_t and data_t.
- One sub-module, fifo_ptr: pointer register with wrap-MSB, increment enable and async active-low clear. It is instantiated twice (wr/rd).
- The reset synchroniser is inline.

Test Plan:
- Reset then 16 pushes of 0x00..0x0F, no pops:
  - full=1 after the 16th edge; count=16; almost_full from count=12.
  - ram_wr_addr 0..15; a 17th push gives overflow=1 for one cycle, no ram_wr_enb, count stays 16.
- From full, 16 pops:
  - pop_valid one cycle after each pop; pop_data 0x00..0x0F in order; empty=1 after the 16th.
  - A 17th pop gives underflow=1, no ram_rd_enb.
- Wrap-around: push 10, pop 10, push 12 (0xA0..0xAB):
  - Write addresses 10..15 then 0..5; count=12; almost_full=1.
  - 12 pops return 0xA0..0xAB.
- Simultaneous push+pop for 20 cycles at count=5: count stays 5; data order is preserved end to end.
- Push and pop in the same cycle while empty: push accepted, underflow=1, count=1; the next pop returns the pushed value.
- Assert rst=0 asynchronously mid-clock with count=7 and a pop in flight:
  - count=0, empty=1, pop_valid=0 immediately.
  - After release, push 0x55 then pop returns 0x55 from address 0.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared widths, defaults and types for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_ADDR_WIDTH   = 4;
    localparam int unsigned DEF_AFULL_THRESH = 12;
    localparam int unsigned DEPTH            = 2 ** DEF_ADDR_WIDTH;
    localparam int unsigned PTR_WIDTH        = DEF_ADDR_WIDTH + 1;

    typedef logic [PTR_WIDTH-1:0]      ptr_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// FIFO pointer with wrap bit: the extra MSB toggles each time the address bits roll over.
module ram_fifo_ctrl_fifo_ptr
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] ptr_nxt_c
);

    // Plain binary increment carries naturally into the wrap MSB.
    assign ptr_nxt_c = inc ? ptr + WIDTH'(1) : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt_c;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM; holds pointers, occupancy and flags only.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH = DEF_AFULL_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_enb,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_enb,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          push_ok;
    logic          pop_ok;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] count_nxt;
    logic          full_nxt;
    logic          empty_nxt;

    // Asynchronous assert, two-flop synchronised release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Push and pop are judged independently against the registered flags.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    ram_fifo_ctrl_fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (push_ok),
        .ptr       (wr_ptr),
        .ptr_nxt_c (wr_ptr_nxt)
    );

    ram_fifo_ctrl_fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (pop_ok),
        .ptr       (rd_ptr),
        .ptr_nxt_c (rd_ptr_nxt)
    );

    assign ram_wr_enb  = push_ok;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_enb  = pop_ok;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // RAM read data lands the cycle after rd_enb, aligned with pop_valid.
    assign pop_data = pop_valid ? ram_rd_data : '0;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + PW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - PW'(1);
        end
    end

    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_nxt  = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                       (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            pop_valid   <= 1'b0;
        end else begin
            count       <= count_nxt;
            empty       <= empty_nxt;
            full        <= full_nxt;
            almost_full <= (count_nxt >= PW'(AFULL_THRESH));
            overflow    <= push && full;
            underflow   <= pop && empty;
            pop_valid   <= pop_ok;
        end
    end

endmodule
